// File: rtl/fifo_axis_pkt.sv
// Single-clock AXI-Stream FIFO with tlast pass-through, optional
// store-and-forward packet mode, occupancy level, packet count and
// almost-full / almost-empty flags.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   s_tvalid/s_tready/s_tdata/s_tlast   slave (write) AXI-Stream side
//   m_tvalid/m_tready/m_tdata/m_tlast   master (read) AXI-Stream side
//   level        entries currently stored (0..DEPTH)
//   pkt_count    stored entries that carry tlast
//   almost_full  level >= AF_THRESH
//   almost_empty level <= AE_THRESH
module fifo_axis_pkt #(
  parameter int unsigned DATAWIDTH   = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned PTR_WIDTH   = 4,
  parameter int unsigned PACKET_MODE = 0,
  parameter int unsigned AF_THRESH   = 12,
  parameter int unsigned AE_THRESH   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [DATAWIDTH-1:0] s_tdata,
  input  logic                 s_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [DATAWIDTH-1:0] m_tdata,
  output logic                 m_tlast,
  output logic [PTR_WIDTH:0]   level,
  output logic [PTR_WIDTH:0]   pkt_count,
  output logic                 almost_full,
  output logic                 almost_empty
);

  localparam int unsigned LVL_W  = PTR_WIDTH + 1;
  localparam int unsigned WORD_W = DATAWIDTH + 1;
  localparam bit          PKT_EN = (PACKET_MODE != 0);

  logic [WORD_W-1:0]    mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [LVL_W-1:0]     pkt_q, pkt_d;

  logic              full_c;
  logic              not_empty_c;
  logic              wr_en_c;
  logic              rd_en_c;
  logic [WORD_W-1:0] rd_word_c;

  // Status derived purely from registered state
  assign full_c      = (level_q == LVL_W'(DEPTH));
  assign not_empty_c = (level_q != '0);

  assign s_tready = ~full_c;
  // Packet mode waits for a complete packet; a full FIFO releases anyway so
  // packets longer than DEPTH cannot deadlock.
  assign m_tvalid = not_empty_c & (~PKT_EN | (pkt_q != '0) | full_c);

  assign wr_en_c = s_tvalid & s_tready;
  assign rd_en_c = m_tvalid & m_tready;

  assign rd_word_c = mem_q[rd_ptr_q];
  assign m_tdata   = rd_word_c[DATAWIDTH-1:0];
  assign m_tlast   = rd_word_c[DATAWIDTH];

  assign level        = level_q;
  assign pkt_count    = pkt_q;
  assign almost_full  = (level_q >= LVL_W'(AF_THRESH));
  assign almost_empty = (level_q <= LVL_W'(AE_THRESH));

  // Next-state for pointers and counters
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    pkt_d    = pkt_q;

    if (wr_en_c) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
    if (rd_en_c) rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);

    case ({wr_en_c, rd_en_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    case ({wr_en_c & s_tlast, rd_en_c & m_tlast})
      2'b10:   pkt_d = pkt_q + LVL_W'(1);
      2'b01:   pkt_d = pkt_q - LVL_W'(1);
      default: pkt_d = pkt_q;
    endcase
  end

  // Control registers; reset wins over any handshake in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pkt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pkt_q    <= pkt_d;
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en_c && !rst) mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
  end

endmodule

// File: tb/tb_fifo_axis_pkt.sv
// Bench for fifo_axis_pkt: one cut-through and one packet-mode instance.
// Expected words are queued as stimulus is issued; a forked monitor pops
// and compares whenever an instance completes a read handshake.
module tb_fifo_axis_pkt;

  logic clk;
  logic rst;

  logic       ct_sv, ct_sr, ct_sl, ct_mv, ct_mr, ct_ml, ct_af, ct_ae;
  logic [7:0] ct_sd, ct_md;
  logic [2:0] ct_lvl, ct_pkt;

  logic       pk_sv, pk_sr, pk_sl, pk_mv, pk_mr, pk_ml, pk_af, pk_ae;
  logic [7:0] pk_sd, pk_md;
  logic [2:0] pk_lvl, pk_pkt;

  int total;
  int bad;

  logic [8:0] ct_q[$];
  logic [8:0] pk_q[$];

  fifo_axis_pkt #(
    .DATAWIDTH(8), .DEPTH(4), .PTR_WIDTH(2), .PACKET_MODE(0),
    .AF_THRESH(3), .AE_THRESH(1)
  ) u_ct (
    .clk(clk), .rst(rst),
    .s_tvalid(ct_sv), .s_tready(ct_sr), .s_tdata(ct_sd), .s_tlast(ct_sl),
    .m_tvalid(ct_mv), .m_tready(ct_mr), .m_tdata(ct_md), .m_tlast(ct_ml),
    .level(ct_lvl), .pkt_count(ct_pkt),
    .almost_full(ct_af), .almost_empty(ct_ae)
  );

  fifo_axis_pkt #(
    .DATAWIDTH(8), .DEPTH(4), .PTR_WIDTH(2), .PACKET_MODE(1),
    .AF_THRESH(3), .AE_THRESH(1)
  ) u_pk (
    .clk(clk), .rst(rst),
    .s_tvalid(pk_sv), .s_tready(pk_sr), .s_tdata(pk_sd), .s_tlast(pk_sl),
    .m_tvalid(pk_mv), .m_tready(pk_mr), .m_tdata(pk_md), .m_tlast(pk_ml),
    .level(pk_lvl), .pkt_count(pk_pkt),
    .almost_full(pk_af), .almost_empty(pk_ae)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ct_sv = 1'b0; ct_sd = 8'h00; ct_sl = 1'b0; ct_mr = 1'b0;
    pk_sv = 1'b0; pk_sd = 8'h00; pk_sl = 1'b0; pk_mr = 1'b0;

    // Monitor: a read handshake is visible at the negedge before its edge
    fork
      forever begin
        logic [8:0] e;
        @(negedge clk);
        if (!rst && ct_mv && ct_mr) begin
          total++;
          if (ct_q.size() == 0) begin
            bad++;
            $display("FAIL ct_unexpected_read actual=%h expected=none", {ct_ml, ct_md});
          end else begin
            e = ct_q.pop_front();
            if ({ct_ml, ct_md} != e) begin
              bad++;
              $display("FAIL ct_read actual=%h expected=%h", {ct_ml, ct_md}, e);
            end
          end
        end
        if (!rst && pk_mv && pk_mr) begin
          total++;
          if (pk_q.size() == 0) begin
            bad++;
            $display("FAIL pk_unexpected_read actual=%h expected=none", {pk_ml, pk_md});
          end else begin
            e = pk_q.pop_front();
            if ({pk_ml, pk_md} != e) begin
              bad++;
              $display("FAIL pk_read actual=%h expected=%h", {pk_ml, pk_md}, e);
            end
          end
        end
      end
    join_none

    // 1. Reset held with a write attempt in flight
    #1;
    ct_sv = 1'b1; ct_sd = 8'hAA;
    tick();
    tick();
    rst = 1'b0; ct_sv = 1'b0;
    chk("rst_s_tready", int'(ct_sr), 1);
    chk("rst_m_tvalid", int'(ct_mv), 0);
    chk("rst_level", int'(ct_lvl), 0);
    chk("rst_almost_empty", int'(ct_ae), 1);
    chk("rst_almost_full", int'(ct_af), 0);
    chk("rst_pkt_count", int'(ct_pkt), 0);
    chk("rst_pk_m_tvalid", int'(pk_mv), 0);

    // 2. Fill 0..3 with m_tready low, then drain
    for (int i = 0; i < 4; i++) begin
      ct_sv = 1'b1; ct_sd = 8'(i); ct_sl = (i == 3);
      ct_q.push_back({ct_sl, ct_sd});
      tick();
      chk("fill_level", int'(ct_lvl), i + 1);
      chk("fill_almost_full", int'(ct_af), (i + 1 >= 3) ? 1 : 0);
      chk("fill_s_tready", int'(ct_sr), (i + 1 != 4) ? 1 : 0);
      chk("fill_m_tvalid", int'(ct_mv), 1);
    end
    ct_sv = 1'b0; ct_sl = 1'b0;
    chk("fill_pkt_count", int'(ct_pkt), 1);
    ct_mr = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    ct_mr = 1'b0;
    chk("drain_m_tvalid", int'(ct_mv), 0);
    chk("drain_level", int'(ct_lvl), 0);
    chk("drain_almost_empty", int'(ct_ae), 1);
    chk("drain_pkt_count", int'(ct_pkt), 0);

    // 3. Full with a blocked write and a one-cycle read
    for (int i = 0; i < 4; i++) begin
      ct_sv = 1'b1; ct_sd = 8'(i);
      ct_q.push_back({1'b0, ct_sd});
      tick();
    end
    chk("full_level", int'(ct_lvl), 4);
    ct_sd = 8'd9;
    ct_q.push_back({1'b0, 8'd9});
    ct_mr = 1'b1;
    tick();
    ct_mr = 1'b0;
    chk("full_rd_level", int'(ct_lvl), 3);
    chk("full_rd_s_tready", int'(ct_sr), 1);
    tick();
    ct_sv = 1'b0;
    chk("full_refill_level", int'(ct_lvl), 4);
    chk("full_refill_s_tready", int'(ct_sr), 0);
    ct_mr = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    ct_mr = 1'b0;
    chk("full_drain_level", int'(ct_lvl), 0);

    // 4. Wrap-around with interleaved single write/read pairs
    for (int i = 0; i < 10; i++) begin
      ct_sv = 1'b1; ct_sd = 8'h10 + 8'(i);
      ct_q.push_back({1'b0, ct_sd});
      tick();
      ct_sv = 1'b0;
      chk("wrap_level_w", int'(ct_lvl), 1);
      chk("wrap_m_tvalid", int'(ct_mv), 1);
      ct_mr = 1'b1;
      tick();
      ct_mr = 1'b0;
      chk("wrap_level_r", int'(ct_lvl), 0);
    end

    // 5. Packet mode: held until tlast is written
    for (int i = 0; i < 3; i++) begin
      pk_sv = 1'b1; pk_sd = 8'h21 + 8'(i); pk_sl = (i == 2);
      pk_q.push_back({pk_sl, pk_sd});
      tick();
      chk("pkt_m_tvalid", int'(pk_mv), (i == 2) ? 1 : 0);
      chk("pkt_level", int'(pk_lvl), i + 1);
    end
    pk_sv = 1'b0; pk_sl = 1'b0;
    chk("pkt_count_one", int'(pk_pkt), 1);
    pk_mr = 1'b1;
    tick();
    tick();
    chk("pkt_count_mid", int'(pk_pkt), 1);
    tick();
    pk_mr = 1'b0;
    chk("pkt_count_zero", int'(pk_pkt), 0);
    chk("pkt_done_m_tvalid", int'(pk_mv), 0);

    // 6. Oversize packet released by the full condition
    for (int i = 0; i < 4; i++) begin
      pk_sv = 1'b1; pk_sd = 8'h30 + 8'(i); pk_sl = 1'b0;
      pk_q.push_back({1'b0, pk_sd});
      tick();
      chk("big_m_tvalid", int'(pk_mv), (i == 3) ? 1 : 0);
    end
    pk_sv = 1'b0;
    chk("big_s_tready", int'(pk_sr), 0);
    pk_mr = 1'b1;
    tick();
    pk_mr = 1'b0;
    chk("big_after_rd_level", int'(pk_lvl), 3);
    chk("big_after_rd_m_tvalid", int'(pk_mv), 0);
    tick();
    chk("big_hold_m_tvalid", int'(pk_mv), 0);
    pk_sv = 1'b1; pk_sd = 8'h34; pk_sl = 1'b1;
    pk_q.push_back({1'b1, 8'h34});
    tick();
    pk_sv = 1'b0; pk_sl = 1'b0;
    chk("big_last_level", int'(pk_lvl), 4);
    chk("big_last_pkt", int'(pk_pkt), 1);
    chk("big_last_m_tvalid", int'(pk_mv), 1);
    pk_mr = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    pk_mr = 1'b0;
    chk("big_end_level", int'(pk_lvl), 0);
    chk("big_end_pkt", int'(pk_pkt), 0);
    chk("big_end_m_tvalid", int'(pk_mv), 0);

    // Every queued word must have been read
    tick();
    chk("ct_queue_left", ct_q.size(), 0);
    chk("pk_queue_left", pk_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_axis_pkt.md
Name: fifo_axis_pkt

Overview:
Parametrised successor to the team's single-clock AXI-Stream FIFO. Adds tlast pass-through, an optional packet (store-and-forward) mode, an occupancy count, programmable almost-full and almost-empty flags, and a count of complete packets held. It sits between AXI-Stream producer/consumer blocks on the same clock domain.

Parameters:
DATAWIDTH, 8, tdata width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
PTR_WIDTH, 4, log2(DEPTH); the caller must keep it consistent with DEPTH
PACKET_MODE, 0, 0 = cut-through; 1 = store-and-forward on tlast
AF_THRESH, 12, almost_full asserts when level >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH (0..DEPTH-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
s_tvalid  in  1  slave data valid
s_tready  out  1  slave ready
s_tdata  in  DATAWIDTH  slave data
s_tlast  in  1  slave end-of-packet
m_tvalid  out  1  master data valid
m_tready  in  1  master ready
m_tdata  out  DATAWIDTH  master data
m_tlast  out  1  master end-of-packet
level  out  PTR_WIDTH+1  entries currently stored (0..DEPTH)
pkt_count  out  PTR_WIDTH+1  complete packets stored (entries with tlast set)
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Storage: DEPTH x (DATAWIDTH+1) array holding {tlast, tdata}. Write and read pointers are PTR_WIDTH bits wide and wrap from DEPTH-1 to 0. level is a separate register of PTR_WIDTH+1 bits.
- Reset (rst=1 at a clk edge): both pointers = 0, level = 0, pkt_count = 0. Resulting outputs: s_tready=1, m_tvalid=0, almost_empty=1, almost_full=0. Array contents are not reset.
- Reset mid-operation discards all stored data and takes priority over any handshake in the same cycle.
- Write handshake: s_tvalid & s_tready at an edge stores the word and advances the write pointer.
- s_tready = (level != DEPTH). It is derived only from registered state and has no combinational path from s_tvalid or m_tready.
- Read handshake: m_tvalid & m_tready at an edge advances the read pointer.
- m_tdata and m_tlast are driven from the array at the read pointer, as a combinational array read. They are don't-care while m_tvalid=0.
- m_tvalid when PACKET_MODE=0: level != 0.
- m_tvalid when PACKET_MODE=1: level != 0 and (pkt_count != 0 or level == DEPTH). The level == DEPTH term is the deadlock release for packets longer than DEPTH; in that case words stream out cut-through until the FIFO is no longer full.
- AXIS rule: once m_tvalid is asserted it stays high until the transfer completes.
  - This holds because only a read can reduce level or pkt_count.
  - A write can only raise them, except when the write is blocked because level == DEPTH.
- level update: +1 on write only, -1 on read only, unchanged when both occur or neither occurs.
- pkt_count update: +1 on a write with s_tlast=1; -1 on a read with m_tlast=1; unchanged when both occur in the same cycle.
- Latency: a word written at edge N is presented with m_tvalid=1 in the cycle after edge N.
  - Cut-through: if the FIFO was empty, the written word is presented immediately.
  - Packet mode: a word is not presented until a tlast word is written, unless the level == DEPTH release applies.
- Full: at level==DEPTH a simultaneous read is allowed and a write is not, because s_tready=0. level becomes DEPTH-1 and s_tready=1 in the next cycle.
- Empty: no read can occur because m_tvalid=0. A write into an empty FIFO does not bypass the array.
- Flags almost_full and almost_empty are combinational compares on the registered level.

Test Plan:
Use DATAWIDTH=8, DEPTH=4, PTR_WIDTH=2, AF_THRESH=3, AE_THRESH=1 for all scenarios.
1. Reset: assert rst for 2 cycles while s_tvalid=1 and s_tdata=0xAA -> s_tready=1, m_tvalid=0, level=0, almost_empty=1. Nothing is stored.
2. Fill then drain, PACKET_MODE=0, m_tready=0: write 0..3 -> level 1,2,3,4; almost_full asserts at level 3; s_tready=0 at level 4. Then set m_tready=1 -> read 0,1,2,3 in order, then m_tvalid=0.
3. Full with a simultaneous event: at level 4, hold s_tvalid=1 with data 9 and pulse m_tready for 1 cycle -> word 0 out, level=3. 9 is accepted on the following edge and the FIFO is full again.
4. Wrap-around: 10 interleaved single write/read pairs (data 0x10..0x19) -> output order identical to input, level never exceeds 1.
5. Packet mode, PACKET_MODE=1: write 3 words with tlast only on the third (0x21,0x22,0x23) -> m_tvalid stays 0 after the first two writes and rises the cycle after the third. Read gives 0x21,0x22,0x23 with m_tlast=1 on 0x23, and pkt_count goes 1 -> 0.
6. Oversize packet, PACKET_MODE=1: write 5 words with tlast only on the 5th -> m_tvalid=1 when level reaches 4. After one read, m_tvalid=0 with level=3 until the tlast word is written. All 5 words are eventually received in order.
